// File: rtl/alu_pkg.sv
// Shared widths, command record and issue-state encoding for the ALU issue queue.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int CMD_W  = 2 * DATA_W + SEL_W;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
  } alu_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command buffer with push/pop and an occupancy count.
// The caller never pushes when full or pops when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = CMD_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Pointers are exactly log2(DEPTH) bits, so wrap-around is free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage has no reset; an entry is only read after it was written, so X is never visible.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/alu_issue_queue.sv
// Command queue feeding an ALU through a registered operand stage.
// The stage refills from the queue head whenever it is empty or not stalled.
module alu_issue_queue #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = alu_pkg::DATA_W,
  parameter  int SEL_W  = alu_pkg::SEL_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              stall,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [SEL_W-1:0]  selection,
  output logic              op_valid,
  output logic [LVL_W-1:0]  level
);

  localparam int CMD_W = 2 * DATA_W + SEL_W;

  alu_pkg::issue_state_e state_q, state_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CMD_W-1:0]      head;
  logic [LVL_W-1:0]      fifo_level;
  logic                  push;
  logic                  load;
  logic                  pop;

  // Ready depends only on the registered level, so a same-cycle pop never frees a slot.
  assign in_ready = reset && (fifo_level < LVL_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = (state_q == alu_pkg::IDLE) || !stall;
  assign pop      = load && (fifo_level != '0);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({in_a, in_b, in_sel}),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    if (load) begin
      if (pop) begin
        {a_d, b_d, sel_d} = head;
        state_d           = alu_pkg::ISSUE;
      end else begin
        state_d = alu_pkg::IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= alu_pkg::IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign selection = sel_q;
  assign op_valid  = (state_q == alu_pkg::ISSUE);
  assign level     = fifo_level;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: per-cycle vector table plus scoreboarded sequences
// for streaming, stall toggling and asynchronous reset.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [3:0] in_sel = '0;
  logic       stall = 1'b0;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] selection;
  logic       op_valid;
  logic [2:0] level;

  int n_checks   = 0;
  int n_fail     = 0;
  int n_consumed = 0;
  alu_cmd_t sb[$];

  always #5 clock = ~clock;

  alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(8), .SEL_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .stall     (stall),
    .a         (a),
    .b         (b),
    .selection (selection),
    .op_valid  (op_valid),
    .level     (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer view: a command is taken when op_valid && !stall at the next edge.
  always @(negedge clock) begin : monitor
    alu_cmd_t got;
    alu_cmd_t exp_cmd;
    if (!reset) begin
      sb.delete();
    end else begin
      if (op_valid && !stall) begin
        got = '{a: a, b: b, sel: selection};
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_cmd = sb.pop_front();
          check("issue_order", 32'(got), 32'(exp_cmd));
        end
        n_consumed++;
      end
      if (in_valid && in_ready) sb.push_back('{a: in_a, b: in_b, sel: in_sel});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic       st;
    logic       ev;
    logic [7:0] ea;
    logic [2:0] el;
    logic       er;
  } vec_t;

  task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                       input logic [3:0] ds, input logic st);
    in_valid = v;
    in_a     = da;
    in_b     = db;
    in_sel   = ds;
    stall    = st;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t vecs[16];
    int   base;
    int   cnt;
    int   run;
    int   max_run;
    int   idx;
    logic done;
    logic rdy;
    logic prev_valid;
    logic [7:0] prev_a;

    //           v  a      b      sel   st  ev  ea     el    er
    vecs[0]  = '{1, 8'h0F, 8'h01, 4'h0, 0,  0,  8'h00, 3'd1, 1};
    vecs[1]  = '{0, 8'h00, 8'h00, 4'h0, 0,  1,  8'h0F, 3'd0, 1};
    vecs[2]  = '{0, 8'h00, 8'h00, 4'h0, 0,  0,  8'h0F, 3'd0, 1};
    vecs[3]  = '{1, 8'h10, 8'hE0, 4'h1, 1,  0,  8'h0F, 3'd1, 1};
    vecs[4]  = '{1, 8'h11, 8'hE1, 4'h2, 1,  1,  8'h10, 3'd1, 1};
    vecs[5]  = '{1, 8'h12, 8'hE2, 4'h3, 1,  1,  8'h10, 3'd2, 1};
    vecs[6]  = '{1, 8'h13, 8'hE3, 4'h4, 1,  1,  8'h10, 3'd3, 1};
    vecs[7]  = '{1, 8'h14, 8'hE4, 4'h5, 1,  1,  8'h10, 3'd4, 0};
    vecs[8]  = '{1, 8'h15, 8'hE5, 4'hF, 1,  1,  8'h10, 3'd4, 0};
    vecs[9]  = '{1, 8'h15, 8'hE5, 4'hF, 1,  1,  8'h10, 3'd4, 0};
    vecs[10] = '{1, 8'h15, 8'hE5, 4'hF, 0,  1,  8'h11, 3'd3, 1};
    vecs[11] = '{1, 8'h15, 8'hE5, 4'hF, 0,  1,  8'h12, 3'd3, 1};
    vecs[12] = '{0, 8'h00, 8'h00, 4'h0, 0,  1,  8'h13, 3'd2, 1};
    vecs[13] = '{0, 8'h00, 8'h00, 4'h0, 0,  1,  8'h14, 3'd1, 1};
    vecs[14] = '{0, 8'h00, 8'h00, 4'h0, 0,  1,  8'h15, 3'd0, 1};
    vecs[15] = '{0, 8'h00, 8'h00, 4'h0, 0,  0,  8'h15, 3'd0, 1};

    // Held in reset
    repeat (2) @(posedge clock);
    #1;
    check("rst_outputs", {a, b, selection, op_valid}, 0);
    check("rst_level", level, 0);
    check("rst_ready", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("ready_after_rst", in_ready, 1);

    // Single push latency, fill with stall, full-queue pop without push
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].st);
      step();
      check($sformatf("v%0d_valid", i), op_valid, vecs[i].ev);
      check($sformatf("v%0d_a", i), a, vecs[i].ea);
      check($sformatf("v%0d_level", i), level, vecs[i].el);
      check($sformatf("v%0d_ready", i), in_ready, vecs[i].er);
    end
    check("table_sb_empty", sb.size(), 0);

    // Back-to-back stream of 8 commands with no stall
    base    = n_consumed;
    cnt     = 0;
    run     = 0;
    max_run = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(1'b1, 8'(i), 8'(i + 8'h40), 4'(i), 1'b0);
      else       drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
      step();
      check($sformatf("stream_level_%0d", i), 32'(level <= 3'd1), 1);
      if (op_valid) begin
        cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("stream_valid_cycles", cnt, 8);
    check("stream_valid_run", max_run, 8);
    check("stream_consumed", n_consumed - base, 8);

    // Stall toggling every cycle across pointer wrap
    base = n_consumed;
    idx  = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      drive(idx < 6, 8'(8'h20 + idx), 8'(8'h80 + idx), 4'(idx + 9), c[0]);
      rdy        = in_ready;
      prev_valid = op_valid;
      prev_a     = a;
      step();
      if (in_valid && rdy) idx++;
      if (stall && prev_valid) check($sformatf("stall_hold_%0d", c), {op_valid, a}, {1'b1, prev_a});
      done = (idx == 6) && (level == 0) && !op_valid;
    end
    check("toggle_drained", done, 1);
    check("toggle_consumed", n_consumed - base, 6);
    check("toggle_sb_empty", sb.size(), 0);

    // Asynchronous reset with level 3 and a live issued command
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h30 + i), 8'(8'h70 + i), 4'(i + 4), 1'b1);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
    check("pre_rst_level", level, 3);
    check("pre_rst_valid", op_valid, 1);
    base = n_consumed;
    #2 reset = 1'b0;
    #1;
    check("async_rst_outputs", {a, b, selection, op_valid}, 0);
    check("async_rst_level", level, 0);
    check("async_rst_ready", in_ready, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (op_valid) cnt++;
    end
    check("no_stale_issue", cnt, 0);
    check("post_rst_level", level, 0);
    check("post_rst_consumed", n_consumed - base, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued commands (power of two, >=2).
REQ-002 Parameter DATA_W, default 8, operand width.
REQ-003 Parameter SEL_W, default 4, operation-select width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream command present.
REQ-007 in_ready  output  1  queue can accept a command this cycle.
REQ-008 in_a  input  DATA_W  operand A of offered command.
REQ-009 in_b  input  DATA_W  operand B of offered command.
REQ-010 in_sel  input  SEL_W  operation select of offered command.
REQ-011 stall  input  1  ALU side not consuming; hold current issued command.
REQ-012 a  output  DATA_W  registered operand A to ALU.
REQ-013 b  output  DATA_W  registered operand B to ALU.
REQ-014 selection  output  SEL_W  registered operation select to ALU.
REQ-015 op_valid  output  1  a/b/selection hold a live command this cycle.
REQ-016 level  output  $clog2(DEPTH)+1  commands held in queue, excluding the issued one.

Function
REQ-017 Push occurs on a rising edge where in_valid && in_ready; {in_a,in_b,in_sel} written at the write pointer.
REQ-018 in_ready = (level < DEPTH), combinational from registered level; no push when full, even if a pop occurs in the same cycle.
REQ-019 Issue FSM states: IDLE (op_valid=0) and ISSUE (op_valid=1).
REQ-020 Output register loads when (state==IDLE || !stall); load takes the queue head if level>0.
REQ-021 IDLE -> ISSUE on an edge where level>0; head popped into a/b/selection.
REQ-022 ISSUE -> ISSUE on an edge where !stall && level>0; next head popped.
REQ-023 ISSUE -> IDLE on an edge where !stall && level==0; a/b/selection retain last values.
REQ-024 ISSUE with stall=1: state, a, b, selection, op_valid unchanged; no pop.
REQ-025 stall in IDLE has no effect; an available head is still loaded.
REQ-026 Latency: command pushed into an empty queue at edge k (IDLE) is presented with op_valid=1 after edge k+1.
REQ-027 Simultaneous push and pop: level unchanged; pointers both advance.
REQ-028 Pointers wrap modulo DEPTH; commands issued in strict FIFO order.
REQ-029 Throughput: one command per cycle sustained when stall=0 and in_valid=1.
REQ-030 Commands are not modified; selection value passes unchecked (all 2^SEL_W codes legal).

Reset
REQ-031 While reset=0: a=0, b=0, selection=0, op_valid=0, level=0, in_ready=0, state=IDLE, pointers=0.
REQ-032 in_ready=1 on the first cycle after reset deasserts.
REQ-033 Reset mid-operation discards all queued and issued commands immediately (asynchronous), no pops emitted.
REQ-034 Queue storage array needs no reset; contents unobservable while level==0.

Structure
REQ-035 Shared package alu_pkg holds DATA_W, SEL_W constants and typedef alu_cmd_t {a, b, sel}.
REQ-036 Storage and pointers live in sub-module alu_cmd_fifo (push/pop/level); FSM and output register in alu_issue_queue.

Verification
REQ-037 Reset release, single push {a=8'h0F,b=8'h01,sel=4'h0} at edge 1, stall=0 -> op_valid=1 with a=0F,b=01,selection=0 after edge 2, op_valid=0 after edge 3.
REQ-038 Push 5 commands back-to-back with stall=1 (DEPTH=4) -> first issued, level reaches 4, in_ready=0, 6th offer not accepted until stall drops.
REQ-039 Stream 8 commands a=0..7 with stall=0 -> op_valid high 8 consecutive cycles, a=0..7 in order, level stays <=1.
REQ-040 Full queue, stall=0, in_valid=1 -> pop occurs, push rejected that cycle (in_ready=0), level drops to 3, push accepted next cycle.
REQ-041 Assert reset with level=3 and op_valid=1 -> outputs zero immediately; after release level=0, no stale command ever issued.
REQ-042 Toggle stall every cycle over 6 commands -> each command held while stalled, none lost or duplicated, wrap-around order preserved.
